dla_hld_ram_clear_sequencer: RTL and testbench

//  Port-a front end for the dla_hld_ram stack: sweeps every address with zero writes after reset
//  or on request, then passes user port-a traffic through with one register stage. Sits directly

---
 rtl/dla_hld_ram_clear_sequencer.sv | 92 +++++++++
 tb/tb_dla_hld_ram_clear_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dla_hld_ram_clear_sequencer.sv
// rtl/dla_hld_ram_clear_sequencer.sv - port-a zero-sweep sequencer with registered user passthrough
module dla_hld_ram_clear_sequencer #(
  parameter  int DEPTH          = 2560,
  parameter  int WIDTH          = 80,
  parameter  int BE_WIDTH       = 8,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int ADDR           = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                clear_req,
  output logic                busy,
  output logic                done,
  input  logic [ADDR-1:0]     u_a_address,
  input  logic                u_a_read_enable,
  input  logic                u_a_write,
  input  logic [WIDTH-1:0]    u_a_writedata,
  input  logic [BE_WIDTH-1:0] u_a_byteenable,
  input  logic                u_a_in_clock_en,
  output logic                u_a_ready,
  output logic [ADDR-1:0]     a_address,
  output logic                a_read_enable,
  output logic                a_write,
  output logic [WIDTH-1:0]    a_writedata,
  output logic [BE_WIDTH-1:0] a_byteenable,
  output logic                a_in_clock_en
);

  if ((WIDTH % BE_WIDTH) != 0) begin : g_width_check
    $error("WIDTH must be a multiple of BE_WIDTH");
  end
  if (DEPTH < 2) begin : g_depth_check
    $error("DEPTH must be at least 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam state_t          RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
  localparam logic [ADDR-1:0] LAST_ADDR   = ADDR'(DEPTH - 1);

  state_t          state;
  logic [ADDR-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= RESET_STATE;
      cnt           <= '0;
      done          <= 1'b0;
      a_address     <= '0;
      a_read_enable <= 1'b0;
      a_write       <= 1'b0;
      a_writedata   <= '0;
      a_byteenable  <= '0;
      a_in_clock_en <= 1'b0;
    end else if (state == CLEAR) begin
      a_address     <= cnt;
      a_read_enable <= 1'b0;
      a_write       <= 1'b1;
      a_writedata   <= '0;
      a_byteenable  <= '1;
      a_in_clock_en <= 1'b1;
      // Compare before incrementing so a non-power-of-2 depth never wraps past the end.
      if (cnt == LAST_ADDR) begin
        done  <= 1'b1;
        state <= IDLE;
        cnt   <= '0;
      end else begin
        done <= 1'b0;
        cnt  <= cnt + ADDR'(1);
      end
    end else begin
      a_address     <= u_a_address;
      a_read_enable <= u_a_read_enable;
      a_write       <= u_a_write;
      a_writedata   <= u_a_writedata;
      a_byteenable  <= u_a_byteenable;
      a_in_clock_en <= u_a_in_clock_en;
      done          <= 1'b0;
      if (clear_req) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end
  end

  assign busy      = (state == CLEAR);
  assign u_a_ready = ~busy;

endmodule

// File: tb/tb_dla_hld_ram_clear_sequencer.sv
// tb/tb_dla_hld_ram_clear_sequencer.sv - scoreboard bench for the RAM clear sequencer
module tb_dla_hld_ram_clear_sequencer;

  localparam int D0 = 2560;
  localparam int D1 = 3;
  localparam int W  = 80;
  localparam int BW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn, clear_req, u_w, u_r, u_ce;
  logic [11:0]   u_addr;
  logic [W-1:0]  u_data;
  logic [BW-1:0] u_be;

  logic          busy0, done0, rdy0, a_re0, a_we0, a_ce0;
  logic [11:0]   a_addr0;
  logic [W-1:0]  a_data0;
  logic [BW-1:0] a_be0;
  logic          busy1, done1, rdy1, a_re1, a_we1, a_ce1;
  logic [1:0]    a_addr1;
  logic [W-1:0]  a_data1;
  logic [BW-1:0] a_be1;

  dla_hld_ram_clear_sequencer #(.DEPTH(D0), .WIDTH(W), .BE_WIDTH(BW), .CLEAR_ON_RESET(1)) dut0 (
    .clock(clock), .resetn(resetn), .clear_req(clear_req), .busy(busy0), .done(done0),
    .u_a_address(u_addr), .u_a_read_enable(u_r), .u_a_write(u_w), .u_a_writedata(u_data),
    .u_a_byteenable(u_be), .u_a_in_clock_en(u_ce), .u_a_ready(rdy0),
    .a_address(a_addr0), .a_read_enable(a_re0), .a_write(a_we0), .a_writedata(a_data0),
    .a_byteenable(a_be0), .a_in_clock_en(a_ce0)
  );

  dla_hld_ram_clear_sequencer #(.DEPTH(D1), .WIDTH(W), .BE_WIDTH(BW), .CLEAR_ON_RESET(0)) dut1 (
    .clock(clock), .resetn(resetn), .clear_req(clear_req), .busy(busy1), .done(done1),
    .u_a_address(u_addr[1:0]), .u_a_read_enable(u_r), .u_a_write(u_w), .u_a_writedata(u_data),
    .u_a_byteenable(u_be), .u_a_in_clock_en(u_ce), .u_a_ready(rdy1),
    .a_address(a_addr1), .a_read_enable(a_re1), .a_write(a_we1), .a_writedata(a_data1),
    .a_byteenable(a_be1), .a_in_clock_en(a_ce1)
  );

  typedef struct packed {
    logic [11:0]   addr;
    logic          we;
    logic          re;
    logic [W-1:0]  data;
    logic [BW-1:0] be;
    logic          ce;
    logic          done;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  txn_t got0, got1;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: a sweeping instance owes writes m_next..depth-1; otherwise it forwards user requests.
  bit   m_busy[2];
  int   m_next[2];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int i, input txn_t t);
    if (i == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic cycle(input bit cr, input bit w, input bit r, input logic [11:0] addr,
                       input logic [W-1:0] data, input logic [BW-1:0] be, input bit ce,
                       output bit acc);
    clear_req = cr; u_w = w; u_r = r; u_addr = addr; u_data = data; u_be = be; u_ce = ce;
    chk("busy0", busy0, m_busy[0]);
    chk("ready0", rdy0, !m_busy[0]);
    chk("busy1", busy1, m_busy[1]);
    chk("ready1", rdy1, !m_busy[1]);
    acc = !m_busy[0];
    for (int i = 0; i < 2; i++) begin
      int d;
      d = (i == 0) ? D0 : D1;
      if (m_busy[i]) begin
        push(i, '{addr: 12'(m_next[i]), we: 1'b1, re: 1'b0, data: '0, be: {BW{1'b1}},
                  ce: 1'b1, done: (m_next[i] == d - 1)});
        m_next[i]++;
        if (m_next[i] == d) m_busy[i] = 1'b0;
      end else begin
        if (w || r)
          push(i, '{addr: (i == 0) ? addr : {10'b0, addr[1:0]}, we: w, re: r, data: data,
                    be: be, ce: ce, done: 1'b0});
        if (cr) begin
          m_busy[i] = 1'b1;
          m_next[i] = 0;
        end
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    bit acc;
    cycle(1'b0, 1'b0, 1'b0, 12'($urandom), {$urandom, $urandom, $urandom}, 8'($urandom),
          1'($urandom), acc);
  endtask

  // Holds one request until dut0 accepts it, as an upstream stalled on u_a_ready would.
  task automatic rand_xact(input int cr_at, input bit force_w);
    bit            acc, w, r, ce;
    logic [11:0]   addr;
    logic [W-1:0]  data;
    logic [BW-1:0] be;
    int            n;
    w = force_w ? 1'b1 : 1'($urandom);
    r = force_w ? 1'b0 : (!w && $urandom_range(0, 1) == 1);
    addr = 12'($urandom_range(0, D0 - 1));
    data = {$urandom, $urandom, $urandom};
    be = 8'($urandom);
    ce = ($urandom_range(0, 3) != 0);
    n = 0;
    do begin
      cycle(n == cr_at, w, r, addr, data, be, ce, acc);
      n++;
    end while (!acc && n < D0 + 20);
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL hold_timeout got=stalled exp=accepted t=%0t", $time);
    end
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_outs0", {a_addr0, a_we0, a_re0, a_data0, a_be0, a_ce0, done0}, '0);
    chk("rst_outs1", {a_addr1, a_we1, a_re1, a_data1, a_be1, a_ce1, done1}, '0);
    chk("rst_busy0", busy0, 1'b1);
    chk("rst_busy1", busy1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    m_busy[0] = 1'b1; m_busy[1] = 1'b0;
    m_next[0] = 0;    m_next[1] = 0;
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      got0 = '{addr: a_addr0, we: a_we0, re: a_re0, data: a_data0, be: a_be0, ce: a_ce0, done: done0};
      got1 = '{addr: {10'b0, a_addr1}, we: a_we1, re: a_re1, data: a_data1, be: a_be1, ce: a_ce1,
               done: done1};
      if (a_we0 || a_re0 || done0) begin
        if (q0.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected0 got=%h exp=none t=%0t", got0, $time);
        end else chk("port_a0", got0, q0.pop_front());
      end
      if (a_we1 || a_re1 || done1) begin
        if (q1.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected1 got=%h exp=none t=%0t", got1, $time);
        end else chk("port_a1", got1, q1.pop_front());
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    resetn = 1'b0; clear_req = 1'b0; u_w = 1'b0; u_r = 1'b0; u_ce = 1'b0;
    u_addr = '0; u_data = '0; u_be = '0;
    @(posedge clock); #1;
    reset_pulse();

    // Power-up sweep: held user write from cycle 10, repeated clear_req at cycle 100.
    repeat (10) idle_cycle();
    rand_xact(90, 1'b1);

    cycle(1'b0, 1'b1, 1'b0, 12'd5, 80'h1234, 8'h0F, 1'b1, acc);
    cycle(1'b0, 1'b1, 1'b0, 12'd6, 80'hABCD, 8'hF0, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b1, 12'd2, 80'h0, 8'h00, 1'b1, acc);
    repeat (3) idle_cycle();

    // Requested sweep interrupted by reset at cnt==1000.
    cycle(1'b1, 1'b0, 1'b0, 12'd0, 80'h0, 8'h00, 1'b0, acc);
    repeat (1000) idle_cycle();
    reset_pulse();

    for (int k = 0; k < 300; k++)
      rand_xact(($urandom_range(0, 49) == 0) ? 0 : -1, 1'b0);

    repeat (5) idle_cycle();
    chk("drain0", 128'(q0.size()), 128'd0);
    chk("drain1", 128'(q1.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
